vload_pack_buffer: RTL and testbench
====================================

// Module: vload_pack_buffer
// PURPOSE
//   Sits directly downstream of the vector load/store unit (vls). Collects BEAT_W-bit memory response beats for one vector load.
//   Packs them into a VLEN-element FP16 vector and issues a single register-file writeback with valid/ready handshake.
//   The packed vector then feeds the FP16 add/sub datapath via the vector register file.
// PARAMETERS
//   VLEN      8   elements per vector
//   ELEM_W    16  element width (FP16)
//   BEAT_W    32  memory response beat width; must be a multiple of ELEM_W
//   REG_AW    5   vector register index width
//   Derived: EPB = BEAT_W/ELEM_W (elements per beat, 2); NBEATS = VLEN/EPB (4)
// PORTS
//   CLK       in   1              clock
//   nRST      in   1              asynchronous active-low reset
//   req_valid in   1              vls issues a load for destination vd
//   req_vd    in   REG_AW         destination vector register
//   req_ready out  1              block can accept a new load
//   rsp_valid in   1              memory response beat valid
//   rsp_data  in   BEAT_W         beat payload, element 0 in bits [ELEM_W-1:0]
//   rsp_ready out  1              beat accepted this cycle when rsp_valid&rsp_ready
//   wb_valid  out  1              packed vector ready for writeback
//   wb_vd     out  REG_AW         writeback register index
//   wb_data   out  VLEN*ELEM_W    packed vector, element i at [i*ELEM_W +: ELEM_W]
//   wb_ready  in   1              register file accepts writeback
//   busy      out  1              high in any state other than IDLE
// BEHAVIOUR
//   - Reset (async, nRST=0): state=IDLE, beat_cnt=0, vd_q=0, buffer=0. Outputs: req_ready=1, rsp_ready=0, wb_valid=0, wb_vd=0, wb_data=0, busy=0.
//   - FSM IDLE -> COLLECT -> WB -> IDLE.
//   - IDLE: req_ready=1. On req_valid: capture req_vd, clear buffer, beat_cnt=0, go to COLLECT.
//   - COLLECT: rsp_ready=1, req_ready=0.
//     - Each accepted beat k writes elements k*EPB .. k*EPB+EPB-1 from rsp_data slices; beat_cnt++.
//     - Beat count NBEATS-1 accepted -> WB next cycle.
//     - rsp_valid=0 -> hold state indefinitely.
//   - WB: wb_valid=1; wb_vd and wb_data held stable until wb_ready. rsp_ready=0 and req_ready=0.
//     - wb_valid & wb_ready -> IDLE next cycle.
//     - wb_valid never drops without handshake.
//   - Latency: wb_valid rises the cycle after the final beat handshake; min load-to-writeback = NBEATS+1 cycles.
//   - Beats arriving outside COLLECT are not accepted (rsp_ready=0); no beat is dropped or double-written.
//   - No overlap: a new request is accepted only in IDLE, i.e. earliest the cycle after the wb handshake.
//   - beat_cnt is $clog2(NBEATS) bits; it wraps to 0 on leaving COLLECT and never indexes past VLEN-1.
//   - nRST asserted mid-COLLECT or mid-WB aborts the load: partial data discarded, wb_valid drops asynchronously.
//   - Element data is passed bit-exact; no FP interpretation in this block.
// CONFIGURATION
//   VLOAD_PACK_MASK_EN
//   - Defined: adds req_mask (in, VLEN) and wb_mask (out, VLEN).
//     - req_mask is captured with the request.
//     - Element i with mask bit 0 is written as 16'h0000 regardless of rsp_data; wb_mask = captured mask.
//     - Beat count is unchanged (NBEATS beats are still consumed).
//     - wb_mask resets to 0.
//   - Undefined: ports absent; all elements take response data.
// STRUCTURE
//   - vector_types.vh: fp16_t (16-bit), VLEN/ELEM_W constants, vpack_state_t enum {IDLE, COLLECT, WB}.
//   - Single module; FSM, beat counter and packing are all inline. Slicing is a generate loop, so no sub-module is needed.
// TESTING
//   1. Reset then load vd=3 with beats 32'h3C01_3C00, 32'h3C03_3C02, 32'h3C05_3C04, 32'h3C07_3C06, wb_ready=1.
//      -> wb_valid one cycle after beat 4; wb_vd=3; wb_data elem i = 16'h3C00+i.
//   2. Same load with rsp_valid gapped (1 beat per 3 cycles).
//      -> identical wb_data; rsp_ready high throughout COLLECT; busy high.
//   3. wb_ready held 0 for 5 cycles in WB, with req_valid=1 and rsp_valid=1 driven.
//      -> wb_valid and wb_data stable, req_ready=0, rsp_ready=0; handshake on cycle 6, then IDLE.
//   4. nRST pulsed after beat 2 of a load.
//      -> wb_valid=0, busy=0, req_ready=1 immediately; the next load (vd=7, beats 32'hFFFF_FFFF) writes back all-ones with no stale data.
//   5. Back-to-back loads vd=1 then vd=2.
//      -> second req_ready only after the first wb handshake; two writebacks in order.
//   6. (VLOAD_PACK_MASK_EN) req_mask=8'b1010_0101 with beats as in test 1.
//      -> elems 0,2,5,7 = 16'h3C00+i, others 16'h0000; wb_mask=8'hA5.

Source files
------------

// File: rtl/vload_pack_buffer_pkg.sv
// Shared types and constants for the vector-load pack buffer.
//   - Default geometry: VLEN elements of ELEM_W bits, BEAT_W-bit response beats.
//   - FSM state encodings (IDLE / COLLECT / WB).
//   - cnt_w(): width of a counter over n values, never less than 1 bit.
package vload_pack_buffer_pkg;

  localparam int VLEN_DEF   = 8;
  localparam int ELEM_W_DEF = 16;
  localparam int BEAT_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  typedef logic [15:0] fp16_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_WB      = 2'd2;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vload_pack_buffer.sv
// vload_pack_buffer: gathers the memory response beats of one vector load,
// packs them into a VLEN x ELEM_W vector and issues a single register-file
// writeback with a valid/ready handshake.
//
// Ports
//   CLK, nRST             clock, asynchronous active-low reset
//   req_valid/req_vd      load request and destination register (req_ready out)
//   rsp_valid/rsp_data    response beats, element 0 in the low slice (rsp_ready out)
//   wb_valid/wb_vd/wb_data writeback, held stable until wb_ready
//   busy                  high whenever not IDLE
//
// Optional feature macro VLOAD_PACK_MASK_EN: adds req_mask/wb_mask; masked-off
// elements are written as zero, beat consumption is unchanged.
module vload_pack_buffer
  import vload_pack_buffer_pkg::*;
#(
  parameter int VLEN   = VLEN_DEF,
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int BEAT_W = BEAT_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     req_valid,
  input  logic [REG_AW-1:0]        req_vd,
`ifdef VLOAD_PACK_MASK_EN
  input  logic [VLEN-1:0]          req_mask,
  output logic [VLEN-1:0]          wb_mask,
`endif
  output logic                     req_ready,
  input  logic                     rsp_valid,
  input  logic [BEAT_W-1:0]        rsp_data,
  output logic                     rsp_ready,
  output logic                     wb_valid,
  output logic [REG_AW-1:0]        wb_vd,
  output logic [VLEN*ELEM_W-1:0]   wb_data,
  input  logic                     wb_ready,
  output logic                     busy
);

  localparam int EPB    = BEAT_W / ELEM_W;
  localparam int NBEATS = VLEN / EPB;
  localparam int CW     = cnt_w(NBEATS);

  logic [1:0]                   state_q, state_d;
  logic [CW-1:0]                beat_cnt_q, beat_cnt_d;
  logic [REG_AW-1:0]            vd_q, vd_d;
  logic [VLEN-1:0][ELEM_W-1:0]  buf_q, buf_d;
  logic [VLEN-1:0][ELEM_W-1:0]  rsp_elem;
  logic [VLEN-1:0]              elem_en;
  logic                         req_acc, beat_acc, clr;

  assign req_acc  = (state_q == ST_IDLE) && req_valid;
  assign beat_acc = (state_q == ST_COLLECT) && rsp_valid;
  assign clr      = req_acc;

`ifdef VLOAD_PACK_MASK_EN
  logic [VLEN-1:0] mask_q, mask_d;

  always_comb begin
    mask_d = mask_q;
    if (req_acc) mask_d = req_mask;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) mask_q <= '0;
    else       mask_q <= mask_d;
  end

  assign elem_en = mask_q;
  assign wb_mask = mask_q;
`else
  assign elem_en = '1;
`endif

  // Element i always comes from slot i%EPB of the beat; which beat it belongs
  // to is resolved against beat_cnt below.
  for (genvar gi = 0; gi < VLEN; gi++) begin : g_elem
    assign rsp_elem[gi] = elem_en[gi] ? rsp_data[(gi % EPB)*ELEM_W +: ELEM_W] : '0;
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    vd_d       = vd_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          vd_d       = req_vd;
          beat_cnt_d = '0;
          state_d    = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (rsp_valid) begin
          if (beat_cnt_q == CW'(NBEATS-1)) begin
            beat_cnt_d = '0;
            state_d    = ST_WB;
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end
      end
      ST_WB: begin
        if (wb_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    buf_d = buf_q;
    for (int i = 0; i < VLEN; i++) begin
      if (clr)
        buf_d[i] = '0;
      else if (beat_acc && (beat_cnt_q == CW'(i / EPB)))
        buf_d[i] = rsp_elem[i];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      vd_q       <= '0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      vd_q       <= vd_d;
      buf_q      <= buf_d;
    end
  end

  // All handshake outputs decode straight from state so a reset drops them
  // asynchronously and wb_valid can only fall via the WB -> IDLE transition.
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_ready = (state_q == ST_COLLECT);
  assign wb_valid  = (state_q == ST_WB);
  assign busy      = (state_q != ST_IDLE);
  assign wb_vd     = vd_q;
  assign wb_data   = buf_q;

endmodule

// File: tb/tb_vload_pack_buffer.sv
// Self-checking bench for vload_pack_buffer: table-driven loads plus
// hand-written sequences for stall, abort and back-to-back cases; writebacks
// are checked against a scoreboard queue filled when each load is issued.
module tb_vload_pack_buffer;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          req_valid = 1'b0;
  logic [4:0]    req_vd = '0;
  logic [7:0]    req_mask = '1;
  logic [7:0]    wb_mask;
  logic          req_ready;
  logic          rsp_valid = 1'b0;
  logic [31:0]   rsp_data = '0;
  logic          rsp_ready;
  logic          wb_valid;
  logic [4:0]    wb_vd;
  logic [127:0]  wb_data;
  logic          wb_ready = 1'b0;
  logic          busy;

  vload_pack_buffer dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .req_valid (req_valid),
    .req_vd    (req_vd),
`ifdef VLOAD_PACK_MASK_EN
    .req_mask  (req_mask),
    .wb_mask   (wb_mask),
`endif
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .wb_valid  (wb_valid),
    .wb_vd     (wb_vd),
    .wb_data   (wb_data),
    .wb_ready  (wb_ready),
    .busy      (busy)
  );

`ifndef VLOAD_PACK_MASK_EN
  assign wb_mask = '1;
`endif

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]   vd;
    logic [127:0] data;
    logic [7:0]   mask;
  } wb_exp_t;

  typedef struct {
    logic [4:0]       vd;
    logic [3:0][31:0] beats;
    int               gap;
    logic [127:0]     exp_data;
  } vec_t;

  wb_exp_t sb[$];
  vec_t    tbl[3];
  int      checks = 0;
  int      failures = 0;

  localparam logic [127:0] SEQ_DATA = 128'h3C07_3C06_3C05_3C04_3C03_3C02_3C01_3C00;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Checks any writeback handshake that the coming edge will complete, then
  // advances to 1ns after the edge.
  task automatic tick();
    wb_exp_t e;
    if (wb_valid && wb_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected: got vd %0d with empty scoreboard", wb_vd);
      end else begin
        e = sb.pop_front();
        chk("wb_vd", 128'(wb_vd), 128'(e.vd));
        chk("wb_data", wb_data, e.data);
`ifdef VLOAD_PACK_MASK_EN
        chk("wb_mask", 128'(wb_mask), 128'(e.mask));
`endif
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic start_load(input logic [4:0] vd, input logic [7:0] mask, input logic [127:0] exp);
    wb_exp_t e;
    int n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("req_ready_wait", 128'(req_ready), 128'(1));
    req_valid = 1'b1;
    req_vd    = vd;
    req_mask  = mask;
    e.vd = vd; e.data = exp; e.mask = mask;
    sb.push_back(e);
    tick();
    req_valid = 1'b0;
    chk("busy_collect", 128'(busy), 128'(1));
  endtask

  task automatic feed(input logic [3:0][31:0] beats, input int gap);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        rsp_valid = 1'b0;
        chk("rsp_ready_gap", 128'(rsp_ready), 128'(1));
        chk("busy_gap", 128'(busy), 128'(1));
        tick();
      end
      rsp_valid = 1'b1;
      rsp_data  = beats[k];
      chk("rsp_ready_beat", 128'(rsp_ready), 128'(1));
      chk("wb_valid_early", 128'(wb_valid), 128'(0));
      tick();
    end
    rsp_valid = 1'b0;
    chk("wb_valid_latency", 128'(wb_valid), 128'(1));
  endtask

  task automatic finish_wb();
    wb_ready = 1'b1;
    chk("wb_valid_pre_hs", 128'(wb_valid), 128'(1));
    tick();
    wb_ready = 1'b0;
    chk("wb_valid_after_hs", 128'(wb_valid), 128'(0));
    chk("req_ready_after_hs", 128'(req_ready), 128'(1));
    chk("busy_after_hs", 128'(busy), 128'(0));
  endtask

  initial begin
    logic [3:0][31:0] seq_beats;
    logic [3:0][31:0] ones_beats;
    logic [3:0][31:0] b2_beats;
    seq_beats  = {32'h3C07_3C06, 32'h3C05_3C04, 32'h3C03_3C02, 32'h3C01_3C00};
    ones_beats = {4{32'hFFFF_FFFF}};
    b2_beats   = {32'h0BAD_F00D, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666};

    tbl[0] = '{vd: 5'd3,  beats: seq_beats, gap: 0, exp_data: SEQ_DATA};
    tbl[1] = '{vd: 5'd3,  beats: seq_beats, gap: 2, exp_data: SEQ_DATA};
    tbl[2] = '{vd: 5'd31,
               beats: {32'h1234_ABCD, 32'hAAAA_5555, 32'h0001_FC00, 32'h8000_7FFF},
               gap: 1, exp_data: 128'h1234_ABCD_AAAA_5555_0001_FC00_8000_7FFF};

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_req_ready", 128'(req_ready), 128'(1));
    chk("rst_rsp_ready", 128'(rsp_ready), 128'(0));
    chk("rst_wb_valid", 128'(wb_valid), 128'(0));
    chk("rst_wb_vd", 128'(wb_vd), 128'(0));
    chk("rst_wb_data", wb_data, 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
`ifdef VLOAD_PACK_MASK_EN
    chk("rst_wb_mask", 128'(wb_mask), 128'(0));
`endif
    #2 nRST = 1'b1;
    tick();

    // Table-driven loads (plain, gapped, mixed patterns)
    for (int t = 0; t < 3; t++) begin
      start_load(tbl[t].vd, 8'hFF, tbl[t].exp_data);
      feed(tbl[t].beats, tbl[t].gap);
      finish_wb();
    end

    // Writeback stall with noise on req/rsp
    start_load(5'd3, 8'hFF, SEQ_DATA);
    feed(seq_beats, 0);
    req_valid = 1'b1;
    req_vd    = 5'd9;
    rsp_valid = 1'b1;
    rsp_data  = 32'hDEAD_BEEF;
    for (int c = 0; c < 5; c++) begin
      chk("stall_wb_valid", 128'(wb_valid), 128'(1));
      chk("stall_wb_data", wb_data, SEQ_DATA);
      chk("stall_wb_vd", 128'(wb_vd), 128'(3));
      chk("stall_req_ready", 128'(req_ready), 128'(0));
      chk("stall_rsp_ready", 128'(rsp_ready), 128'(0));
      tick();
    end
    req_valid = 1'b0;
    rsp_valid = 1'b0;
    finish_wb();

    // Abort mid-collect via reset
    start_load(5'd5, 8'hFF, 128'h0);
    rsp_valid = 1'b1;
    rsp_data  = 32'h1357_2468;
    tick();
    rsp_data  = 32'h9ABC_DEF0;
    tick();
    rsp_valid = 1'b0;
    nRST = 1'b0;
    #1;
    chk("abort_wb_valid", 128'(wb_valid), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_req_ready", 128'(req_ready), 128'(1));
    chk("abort_wb_data", wb_data, 128'(0));
    sb.delete();
    #1 nRST = 1'b1;
    tick();
    start_load(5'd7, 8'hFF, {128{1'b1}});
    feed(ones_beats, 0);
    finish_wb();

    // Back-to-back loads: second request waits for first handshake
    start_load(5'd1, 8'hFF, SEQ_DATA);
    feed(seq_beats, 0);
    req_valid = 1'b1;
    req_vd    = 5'd2;
    chk("b2b_req_ready_wb", 128'(req_ready), 128'(0));
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("b2b_req_ready_idle", 128'(req_ready), 128'(1));
    begin
      wb_exp_t e2;
      e2.vd = 5'd2; e2.data = 128'h0BAD_F00D_1111_2222_3333_4444_5555_6666; e2.mask = 8'hFF;
      sb.push_back(e2);
    end
    tick();
    req_valid = 1'b0;
    chk("b2b_busy", 128'(busy), 128'(1));
    feed(b2_beats, 1);
    finish_wb();

`ifdef VLOAD_PACK_MASK_EN
    // Masked load
    start_load(5'd3, 8'hA5, 128'h3C07_0000_3C05_0000_0000_3C02_0000_3C00);
    feed(seq_beats, 0);
    finish_wb();
`endif

    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so a stuck handshake still produces a summary.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
